// File: rtl/mem_burst_reader.sv
// Burst read initiator: issues sequential word reads, buffers returns in a credit-limited FIFO.
// Optional bounds checking is compiled in with `define MEM_BURST_READER_BOUNDS_EN.
`timescale 1ns/1ps

package config_pkg;
  parameter int MEM_WORDS = 256;
endpackage

module mem_burst_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = config_pkg::MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_read_en,
  output logic [31:0] mem_read_addr,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   returned_q, returned_d;
  logic [AW:0]   inflight_q, inflight_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_d [FIFO_DEPTH];
  logic          fifo_last_q [FIFO_DEPTH];
  logic          fifo_last_d [FIFO_DEPTH];
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic accept;
  logic issue;
  logic push;
  logic pop;
  logic oob;

`ifdef MEM_BURST_READER_BOUNDS_EN
  logic [32:0] end_addr;
  assign end_addr = {1'b0, cmd_addr} + {17'b0, cmd_len};
  assign oob      = end_addr > 33'(MEM_WORDS);
`else
  logic unused_mem_words;
  assign unused_mem_words = ^MEM_WORDS;
  assign oob              = 1'b0;
`endif

  assign accept = cmd_valid && (state_q == IDLE);
  // Credits cover both words already buffered and reads still in flight.
  assign issue  = (state_q == RUN) && (remaining_q != '0) &&
                  (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_W);
  assign push   = mem_read_valid && (inflight_q != '0);
  assign pop    = (count_q != '0) && out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    len_d       = len_q;
    returned_d  = returned_q;
    inflight_d  = inflight_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
          len_d       = cmd_len;
          returned_d  = '0;
          if (oob) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d      = addr_q + 32'd1;
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case ({issue, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_read_data;
      fifo_last_d[wr_ptr_q] = (returned_q + 16'd1) == len_q;
      returned_d            = returned_q + 16'd1;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      returned_q  <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_data_q <= '{default: '0};
      fifo_last_q <= '{default: 1'b0};
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      len_q       <= len_d;
      returned_q  <= returned_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign out_valid     = (count_q != '0);
  assign out_data      = fifo_data_q[rd_ptr_q];
  assign out_last      = out_valid && fifo_last_q[rd_ptr_q];
  assign done          = done_q;
  assign err           = err_q;
  assign mem_read_en   = issue;
  assign mem_read_addr = addr_q;

endmodule
